// File: rtl/irq_dispatch_seq.sv
// Sequential dispatch stage behind the 27-channel interrupt priority encoder:
// qualifies the winning request, runs the CPU req/ack handshake and masks the in-service channel.
module irq_dispatch_seq #(
  parameter int STABLE_CYCLES = 2,
  parameter int TIMEOUT       = 255,
  parameter int CNT_W         = 8,
  parameter int NCH           = 9
) (
  input  logic           blif_clk_net,
  input  logic           blif_reset_net,
  input  logic           grp_a,
  input  logic           grp_b,
  input  logic           grp_c,
  input  logic [3:0]     chan_num,
  output logic           irq_o,
  input  logic           irq_ack_i,
  output logic [5:0]     vec_o,
  output logic           vec_valid_o,
  input  logic           eoi_i,
  output logic [NCH-1:0] en_mask_o,
  output logic           busy_o,
  output logic           err_o,
  input  logic           err_clr_i
);

  typedef enum logic [1:0] {S_IDLE, S_QUAL, S_REQ, S_SVC} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state, w_state_nxt;
  logic             r_irq, w_irq_nxt;
  logic [5:0]       r_vec, w_vec_nxt;
  logic             r_vv, w_vv_nxt;
  logic [NCH-1:0]   r_mask, w_mask_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_err, w_err_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_tcnt, w_tcnt_nxt;
  logic             w_req, w_chan_ok, w_err_set;
  logic [1:0]       w_grp;
  logic [5:0]       w_sample;

  // State and output registers
  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      r_state <= S_IDLE;
      r_irq   <= 1'b0;
      r_vec   <= 6'd0;
      r_vv    <= 1'b0;
      r_mask  <= {NCH{1'b1}};
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_irq   <= w_irq_nxt;
      r_vec   <= w_vec_nxt;
      r_vv    <= w_vv_nxt;
      r_mask  <= w_mask_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tcnt  <= w_tcnt_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_irq_nxt   = r_irq;
    w_vec_nxt   = r_vec;
    w_vv_nxt    = 1'b0;
    w_mask_nxt  = r_mask;
    w_cnt_nxt   = r_cnt;
    w_tcnt_nxt  = r_tcnt;
    w_err_set   = 1'b0;
    w_req       = grp_a | grp_b | grp_c;
    w_chan_ok   = (chan_num <= 4'd8);
    // Group A outranks B, which outranks C
    if (grp_a) begin
      w_grp = 2'b01;
    end else if (grp_b) begin
      w_grp = 2'b10;
    end else if (grp_c) begin
      w_grp = 2'b11;
    end else begin
      w_grp = 2'b00;
    end
    w_sample = {w_grp, chan_num};

    case (r_state)
      S_IDLE: begin
        if (w_req && w_chan_ok) begin
          w_vec_nxt = w_sample;
          w_cnt_nxt = CNT_ONE;
          if (STABLE_CYCLES == 1) begin
            w_state_nxt = S_REQ;
            w_irq_nxt   = 1'b1;
            w_tcnt_nxt  = '0;
          end else begin
            w_state_nxt = S_QUAL;
          end
        end else if (w_req) begin
          w_err_set = 1'b1;
        end else begin
          w_cnt_nxt = '0;
        end
      end
      S_QUAL: begin
        if (!w_req || !w_chan_ok) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_err_set   = w_req;
        end else if (w_sample == r_vec) begin
          if (r_cnt >= ST_LAST) begin
            w_state_nxt = S_REQ;
            w_irq_nxt   = 1'b1;
            w_tcnt_nxt  = '0;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end else begin
          w_vec_nxt = w_sample;
          w_cnt_nxt = CNT_ONE;
        end
      end
      S_REQ: begin
        // Ack takes precedence over a timeout landing on the same edge
        if (irq_ack_i) begin
          w_vv_nxt               = 1'b1;
          w_irq_nxt              = 1'b0;
          w_mask_nxt[r_vec[3:0]] = 1'b0;
          w_state_nxt            = S_SVC;
          w_tcnt_nxt             = '0;
        end else if (r_tcnt >= TO_LAST) begin
          w_err_set   = 1'b1;
          w_irq_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
          w_tcnt_nxt  = '0;
        end else begin
          w_tcnt_nxt = r_tcnt + CNT_ONE;
        end
      end
      S_SVC: begin
        if (eoi_i) begin
          w_mask_nxt[r_vec[3:0]] = 1'b1;
          w_state_nxt            = S_IDLE;
        end else begin
          w_state_nxt = S_SVC;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_irq_nxt   = 1'b0;
      end
    endcase

    if (w_err_set) begin
      w_err_nxt = 1'b1;
    end else if (err_clr_i) begin
      w_err_nxt = 1'b0;
    end else begin
      w_err_nxt = r_err;
    end
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign irq_o       = r_irq;
  assign vec_o       = r_vec;
  assign vec_valid_o = r_vv;
  assign en_mask_o   = r_mask;
  assign busy_o      = r_busy;
  assign err_o       = r_err;

endmodule

// File: tb/tb_irq_dispatch_seq.sv
// Self-checking bench for irq_dispatch_seq: directed scenarios plus randomized traffic
// compared against a behavioural model of the dispatch rules.
module tb_irq_dispatch_seq;
  localparam int STABLE = 2;
  localparam int TMO    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       grp_a = 1'b0, grp_b = 1'b0, grp_c = 1'b0;
  logic [3:0] chan_num = 4'd0;
  logic       irq_ack = 1'b0, eoi = 1'b0, err_clr = 1'b0;
  logic       irq, vv, busy, err;
  logic [5:0] vec;
  logic [8:0] mask;

  int n_checks = 0;
  int n_errors = 0;

  irq_dispatch_seq #(.STABLE_CYCLES(STABLE), .TIMEOUT(TMO), .CNT_W(8), .NCH(9)) dut (
    .blif_clk_net(clk), .blif_reset_net(rst_n),
    .grp_a(grp_a), .grp_b(grp_b), .grp_c(grp_c), .chan_num(chan_num),
    .irq_o(irq), .irq_ack_i(irq_ack), .vec_o(vec), .vec_valid_o(vv),
    .eoi_i(eoi), .en_mask_o(mask), .busy_o(busy), .err_o(err), .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  // Behavioural model: a candidate with a run length, a pending request with an age,
  // and an in-service flag.
  logic       m_irq, m_vv, m_err;
  logic [5:0] m_vec;
  logic [8:0] m_mask;
  int         m_run, m_age;
  bit         m_in_req, m_in_svc;

  function automatic void m_reset();
    m_irq = 1'b0; m_vv = 1'b0; m_err = 1'b0; m_vec = 6'd0; m_mask = 9'h1FF;
    m_run = 0; m_age = 0; m_in_req = 1'b0; m_in_svc = 1'b0;
  endfunction

  function automatic void m_step(logic a, logic b, logic c, logic [3:0] ch,
                                 logic ack, logic e, logic clr);
    logic [1:0] g;
    bit         set_err;
    set_err = 1'b0;
    m_vv    = 1'b0;
    g = a ? 2'd1 : (b ? 2'd2 : (c ? 2'd3 : 2'd0));
    if (m_in_svc) begin
      if (e) begin m_mask[m_vec[3:0]] = 1'b1; m_in_svc = 1'b0; end
    end else if (m_in_req) begin
      if (ack) begin
        m_vv = 1'b1; m_irq = 1'b0; m_mask[m_vec[3:0]] = 1'b0;
        m_in_req = 1'b0; m_in_svc = 1'b1;
      end else begin
        m_age++;
        if (m_age == TMO) begin set_err = 1'b1; m_irq = 1'b0; m_in_req = 1'b0; end
      end
    end else if (g == 2'd0) begin
      m_run = 0;
    end else if (ch > 4'd8) begin
      set_err = 1'b1; m_run = 0;
    end else begin
      if (m_run > 0 && {g, ch} == m_vec) m_run++;
      else begin m_vec = {g, ch}; m_run = 1; end
      if (m_run >= STABLE) begin m_in_req = 1'b1; m_irq = 1'b1; m_age = 0; m_run = 0; end
    end
    if (set_err) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic a, logic b, logic c, logic [3:0] ch);
    grp_a = a; grp_b = b; grp_c = c; chan_num = ch;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    irq_ack = 1'b0; eoi = 1'b0; err_clr = 1'b0;
    rst_n = 1'b0;
    #7;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if ({irq, vv, busy, err, vec} !== 10'd0 || mask !== 9'h1FF) begin
      n_errors++; $display("FAIL reset_values got irq=%b busy=%b err=%b vec=%h mask=%h", irq, busy, err, vec, mask); end
    drive(1'b1, 1'b0, 1'b0, 4'd1); tick(); tick();
    n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL reset_pre_req got irq=%b exp 1", irq); end
    #2 rst_n = 1'b0; #1;
    n_checks++; if (irq !== 1'b0 || busy !== 1'b0 || mask !== 9'h1FF) begin
      n_errors++; $display("FAIL reset_mid_req got irq=%b busy=%b mask=%h exp 0 0 1ff", irq, busy, mask); end
    @(negedge clk) rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 4'd7); tick(); tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_checks++; if (mask !== 9'h17F) begin n_errors++; $display("FAIL reset_pre_svc got mask=%h exp 17f", mask); end
    #2 rst_n = 1'b0; #1;
    n_checks++; if (mask !== 9'h1FF || busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_mid_svc got mask=%h busy=%b exp 1ff 0", mask, busy); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_stable();
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 4'd5); tick();
    n_checks++; if (irq !== 1'b0 || busy !== 1'b1) begin
      n_errors++; $display("FAIL stable_edge1 got irq=%b busy=%b exp 0 1", irq, busy); end
    tick();
    n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL stable_edge2 got irq=%b exp 1", irq); end
    drive(1'b1, 1'b0, 1'b0, 4'd2); irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_checks++; if (vv !== 1'b1 || irq !== 1'b0 || vec !== 6'b10_0101 || mask !== 9'h1DF) begin
      n_errors++; $display("FAIL stable_ack got vv=%b irq=%b vec=%b mask=%h exp 1 0 100101 1df", vv, irq, vec, mask); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_checks++; if (vv !== 1'b0 || mask !== 9'h1DF || busy !== 1'b1) begin
      n_errors++; $display("FAIL stable_pulse got vv=%b mask=%h busy=%b exp 0 1df 1", vv, mask, busy); end
    drive(1'b0, 1'b0, 1'b0, 4'd0); eoi = 1'b1; tick(); eoi = 1'b0;
    n_checks++; if (mask !== 9'h1FF || busy !== 1'b0) begin
      n_errors++; $display("FAIL stable_eoi got mask=%h busy=%b exp 1ff 0", mask, busy); end
  endtask

  task automatic test_glitch();
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 4'd3); tick();
    drive(1'b0, 1'b0, 1'b1, 4'd4); tick();
    n_checks++; if (irq !== 1'b0 || vec !== 6'b11_0100) begin
      n_errors++; $display("FAIL glitch_restart got irq=%b vec=%b exp 0 110100", irq, vec); end
    tick();
    n_checks++; if (irq !== 1'b1 || vec !== 6'b11_0100) begin
      n_errors++; $display("FAIL glitch_fire got irq=%b vec=%b exp 1 110100", irq, vec); end
  endtask

  task automatic test_timeout();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 4'd6); tick(); tick();
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < TMO - 1; i++) tick();
    n_checks++; if (irq !== 1'b1 || err !== 1'b0) begin
      n_errors++; $display("FAIL timeout_hold got irq=%b err=%b exp 1 0", irq, err); end
    tick();
    n_checks++; if (irq !== 1'b0 || err !== 1'b1 || mask !== 9'h1FF || busy !== 1'b0) begin
      n_errors++; $display("FAIL timeout_abort got irq=%b err=%b mask=%h busy=%b exp 0 1 1ff 0", irq, err, mask, busy); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL timeout_clr got err=%b exp 0", err); end
    drive(1'b1, 1'b0, 1'b0, 4'd6); tick(); tick();
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < TMO - 1; i++) tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_checks++; if (vv !== 1'b1 || err !== 1'b0 || busy !== 1'b1 || mask !== 9'h1BF) begin
      n_errors++; $display("FAIL ack_at_timeout got vv=%b err=%b busy=%b mask=%h exp 1 0 1 1bf", vv, err, busy, mask); end
  endtask

  task automatic test_invalid_priority();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 4'd12); tick(); tick();
    n_checks++; if (err !== 1'b1 || irq !== 1'b0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL invalid_chan got err=%b irq=%b busy=%b exp 1 0 0", err, irq, busy); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL err_set_wins got err=%b exp 1", err); end
    drive(1'b0, 1'b0, 1'b0, 4'd0); err_clr = 1'b1; tick(); err_clr = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 4'd0); tick(); tick();
    n_checks++; if (vec !== 6'b01_0000 || irq !== 1'b1 || err !== 1'b0) begin
      n_errors++; $display("FAIL priority_ac got vec=%b irq=%b err=%b exp 010000 1 0", vec, irq, err); end
  endtask

  task automatic test_random();
    logic [2:0] f;
    logic [3:0] ch;
    do_reset();
    f = 3'b000; ch = 4'd0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        f  = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
        ch = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      end
      drive(f[2], f[1], f[0], ch);
      irq_ack = ($urandom_range(0, 3) == 0);
      eoi     = ($urandom_range(0, 3) == 0);
      err_clr = ($urandom_range(0, 7) == 0);
      tick();
      m_step(f[2], f[1], f[0], ch, irq_ack, eoi, err_clr);
      n_checks++;
      if (irq !== m_irq || vec !== m_vec || vv !== m_vv || mask !== m_mask ||
          err !== m_err || busy !== (m_run > 0 || m_in_req || m_in_svc)) begin
        n_errors++;
        $display("FAIL random_cyc%0d got irq=%b vec=%h vv=%b mask=%h err=%b busy=%b exp irq=%b vec=%h vv=%b mask=%h err=%b",
                 i, irq, vec, vv, mask, err, busy, m_irq, m_vec, m_vv, m_mask, m_err);
      end
    end
    irq_ack = 1'b0; eoi = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stable();
    test_glitch();
    test_timeout();
    test_invalid_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
